// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian words from a host byte stream,
// writes them to instruction memory and releases the core once the image checksum verifies.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  // Largest image that fits between BASE_ADDR and the top of memory.
  localparam logic [16:0] MAX_WORDS = 17'((1 << ADDR_W) - BASE_ADDR);

  state_t      state, next_state;
  logic        accept;
  logic [7:0]  count_hi;
  logic [15:0] count;
  logic [15:0] count_n;
  logic [23:0] word_sr;
  logic [1:0]  byte_idx;
  logic [7:0]  xor_acc;
  logic        last_byte_of_image;

  assign accept             = in_valid && in_ready;
  assign count_n            = {count_hi, in_data};
  assign last_byte_of_image = (byte_idx == 2'd3) && (words_loaded + 16'd1 == count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CNT_HI;
    else     state <= next_state;
  end

  always_comb begin
    // NOTE: next_state is defaulted before the case so every path assigns it and no latch is inferred.
    next_state = state;
    if (reload) begin
      next_state = CNT_HI;
    end else begin
      case (state)
        CNT_HI: if (accept) next_state = CNT_LO;
        CNT_LO: begin
          if (accept) begin
            if ({1'b0, count_n} > MAX_WORDS) next_state = ERR;
            else if (count_n == 16'd0)       next_state = CSUM;
            else                             next_state = DATA;
          end
        end
        DATA:   if (accept && last_byte_of_image) next_state = CSUM;
        CSUM:   if (accept) next_state = ((xor_acc ^ in_data) == 8'h00) ? DONE : ERR;
        default: next_state = state;
      endcase
    end
  end

  // Status flags are registered from next_state so they track the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      in_ready     <= 1'b0;
      core_hold    <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= ADDR_W'(BASE_ADDR);
      mem_wdata    <= 32'd0;
      words_loaded <= 16'd0;
      xor_acc      <= 8'd0;
      byte_idx     <= 2'd0;
      word_sr      <= 24'd0;
      count_hi     <= 8'd0;
      count        <= 16'd0;
    end else begin
      mem_we    <= 1'b0;
      in_ready  <= (next_state inside {CNT_HI, CNT_LO, DATA, CSUM});
      core_hold <= (next_state != DONE);
      load_done <= (next_state == DONE);
      load_err  <= (next_state == ERR);
      if (reload) begin
        words_loaded <= 16'd0;
        xor_acc      <= 8'd0;
        byte_idx     <= 2'd0;
      end else if (accept) begin
        case (state)
          CNT_HI: begin
            count_hi <= in_data;
            xor_acc  <= xor_acc ^ in_data;
          end
          CNT_LO: begin
            count   <= count_n;
            xor_acc <= xor_acc ^ in_data;
          end
          DATA: begin
            xor_acc  <= xor_acc ^ in_data;
            word_sr  <= {word_sr[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we       <= 1'b1;
              mem_addr     <= ADDR_W'(BASE_ADDR) + words_loaded[ADDR_W-1:0];
              mem_wdata    <= {word_sr, in_data};
              words_loaded <= words_loaded + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus pushes expected writes into a queue,
// an independent monitor pops and compares every mem_we cycle.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              reload = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;
  logic [15:0]       words_loaded;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  passed  = 0;
  int  total   = 0;
  int  wr_cnt  = 0;
  int  exp_wrs = 0;

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
    exp_wrs++;
  endtask

  // Monitor: every write the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      wr_t w;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(w.addr));
        check("write_data", mem_wdata, w.data);
      end
    end
  end

  // Presents one byte and returns #1 after the edge that transferred it.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    bit ok;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  logic [7:0] frame2 [10];
  logic [7:0] frame3 [14];

  initial begin
    frame2 = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    frame3 = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44,
               8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01};

    // Reset values while rst is held.
    #12;
    check("rst_core_hold", core_hold, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_words", words_loaded, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", in_ready, 1);

    // Two-word frame, back-to-back, good checksum 0x26.
    expect_write(8'd0, 32'h2001_0005);
    expect_write(8'd1, 32'h0000_0000);
    for (int i = 0; i < 10; i++) begin
      send_byte(frame2[i], 0);
      if (i == 5 || i == 9) check("we_one_cycle_after_4th", mem_we, 1);
      else                  check("we_idle", mem_we, 0);
    end
    send_byte(8'h26, 0);
    idle();
    check("t1_load_done", load_done, 1);
    check("t1_core_hold", core_hold, 0);
    check("t1_words", words_loaded, 2);
    check("t1_in_ready", in_ready, 0);
    check("t1_writes", wr_cnt, exp_wrs);

    pulse_reload();
    check("reload_core_hold", core_hold, 1);
    check("reload_load_done", load_done, 0);
    check("reload_in_ready", in_ready, 1);
    check("reload_words", words_loaded, 0);

    // Same frame with a bad checksum.
    expect_write(8'd0, 32'h2001_0005);
    expect_write(8'd1, 32'h0000_0000);
    for (int i = 0; i < 10; i++) send_byte(frame2[i], 0);
    send_byte(8'h27, 0);
    idle();
    check("t2_load_err", load_err, 1);
    check("t2_core_hold", core_hold, 1);
    check("t2_load_done", load_done, 0);
    check("t2_in_ready", in_ready, 0);
    check("t2_writes", wr_cnt, exp_wrs);

    // Oversize count 0x0101 rejected right after COUNT_LO.
    pulse_reload();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    idle();
    check("t3_load_err", load_err, 1);
    check("t3_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_no_writes", wr_cnt, exp_wrs);

    // Largest legal count 0x0100 is accepted into the data phase.
    pulse_reload();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    idle();
    check("t3b_no_err", load_err, 0);
    check("t3b_in_ready", in_ready, 1);

    // Empty image: 00 00 00.
    pulse_reload();
    for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
    idle();
    check("t4_load_done", load_done, 1);
    check("t4_core_hold", core_hold, 0);
    check("t4_words", words_loaded, 0);
    pulse_reload();
    check("t4_reload_core_hold", core_hold, 1);
    check("t4_reload_load_done", load_done, 0);
    check("t4_reload_in_ready", in_ready, 1);

    // Three-word image with random in_valid gaps, checksum 0x64.
    expect_write(8'd0, 32'h1122_3344);
    expect_write(8'd1, 32'hDEAD_BEEF);
    expect_write(8'd2, 32'h0000_0001);
    for (int i = 0; i < 14; i++) send_byte(frame3[i], 2);
    send_byte(8'h64, 2);
    idle();
    check("t5_load_done", load_done, 1);
    check("t5_words", words_loaded, 3);
    check("t5_writes", wr_cnt, exp_wrs);

    // Restart, then assert rst asynchronously after the first word is written.
    pulse_reload();
    expect_write(8'd0, 32'h1122_3344);
    for (int i = 0; i < 6; i++) send_byte(frame3[i], 2);
    idle();
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_core_hold", core_hold, 1);
    check("arst_mem_we", mem_we, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_words", words_loaded, 0);
    check("arst_mem_addr", 32'(mem_addr), 0);
    check("arst_mem_wdata", mem_wdata, 0);
    check("arst_load_done", load_done, 0);
    check("arst_load_err", load_err, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("arst_in_ready_rise", in_ready, 1);
    check("final_writes", wr_cnt, exp_wrs);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
